// File: rtl/ucontrol_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ucontrol_sequencer_if
// Brief    : Sequencer <-> datapath/control-store signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ucontrol_sequencer_if #(
    parameter int DATAWIDTH_MUX_SELECTION = 6,
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_CSADDR        = 11,
    parameter int DATAWIDTH_MIR           = 41
);
    logic [DATAWIDTH_MIR-1:0]           uControl_CSData_In;
    logic                               uControl_MemReady_InHigh;
    logic                               PSR_Negative_InHigh;
    logic                               PSR_Zero_InHigh;
    logic                               PSR_Overflow_InHigh;
    logic                               PSR_Carry_InHigh;
    logic [1:0]                         RegIR_OP;
    logic [4:0]                         RegIR_RD;
    logic [2:0]                         RegIR_OP2;
    logic [5:0]                         RegIR_OP3;
    logic [4:0]                         RegIR_RS1;
    logic                               RegIR_BIT13;
    logic [4:0]                         RegIR_RS2;
    logic [DATAWIDTH_CSADDR-1:0]        uControl_CSAddress_Out;
    logic [DATAWIDTH_MUX_SELECTION-1:0] MUX_SelectionBUSA_Out;
    logic [DATAWIDTH_MUX_SELECTION-1:0] MUX_SelectionBUSB_Out;
    logic [DATAWIDTH_MUX_SELECTION-1:0] Decoder_SelectionC_Out;
    logic                               uControl_RegWrite_OutHigh;
    logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_Selection_Out;
    logic                               uControl_MemRD_OutHigh;
    logic                               uControl_MemWR_OutHigh;

    modport master (
        input  uControl_CSData_In, uControl_MemReady_InHigh,
        input  PSR_Negative_InHigh, PSR_Zero_InHigh, PSR_Overflow_InHigh, PSR_Carry_InHigh,
        input  RegIR_OP, RegIR_RD, RegIR_OP2, RegIR_OP3, RegIR_RS1, RegIR_BIT13, RegIR_RS2,
        output uControl_CSAddress_Out, MUX_SelectionBUSA_Out, MUX_SelectionBUSB_Out,
        output Decoder_SelectionC_Out, uControl_RegWrite_OutHigh, ALU_Selection_Out,
        output uControl_MemRD_OutHigh, uControl_MemWR_OutHigh
    );

    modport slave (
        output uControl_CSData_In, uControl_MemReady_InHigh,
        output PSR_Negative_InHigh, PSR_Zero_InHigh, PSR_Overflow_InHigh, PSR_Carry_InHigh,
        output RegIR_OP, RegIR_RD, RegIR_OP2, RegIR_OP3, RegIR_RS1, RegIR_BIT13, RegIR_RS2,
        input  uControl_CSAddress_Out, MUX_SelectionBUSA_Out, MUX_SelectionBUSB_Out,
        input  Decoder_SelectionC_Out, uControl_RegWrite_OutHigh, ALU_Selection_Out,
        input  uControl_MemRD_OutHigh, uControl_MemWR_OutHigh
    );
endinterface
`default_nettype wire

// File: rtl/ucontrol_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ucontrol_sequencer
// Brief    : Two-state microprogram sequencer (LOAD/EXEC) driving uDataPath.
// Revision : 1.0 - initial release
// ============================================================================
module ucontrol_sequencer #(
    parameter int                  DATAWIDTH_MUX_SELECTION = 6,
    parameter int                  DATAWIDTH_ALU_SELECTION = 4,
    parameter int                  DATAWIDTH_CSADDR        = 11,
    parameter int                  DATAWIDTH_MIR           = 41,
    parameter logic [10:0]         DATA_CSADDR_INIT        = 11'h000
) (
    input  wire logic              uControl_CLOCK_50,
    input  wire logic              uControl_Reset_InHigh,
    ucontrol_sequencer_if.master   bus
);
    localparam logic [0:0] c_LOAD = 1'b0;
    localparam logic [0:0] c_EXEC = 1'b1;

    logic [0:0]                         r_state;
    logic [DATAWIDTH_CSADDR-1:0]        r_csAddr;
    logic [DATAWIDTH_MIR-1:0]           r_mir;

    logic [DATAWIDTH_MUX_SELECTION-1:0] w_aSel;
    logic [DATAWIDTH_MUX_SELECTION-1:0] w_bSel;
    logic [DATAWIDTH_MUX_SELECTION-1:0] w_cSel;
    logic [DATAWIDTH_ALU_SELECTION-1:0] w_alu;
    logic                               w_rd;
    logic                               w_wr;
    logic [2:0]                         w_cond;
    logic [DATAWIDTH_CSADDR-1:0]        w_jaddr;
    logic [DATAWIDTH_CSADDR-1:0]        w_csarInc;
    logic [DATAWIDTH_CSADDR-1:0]        w_decodeAddr;
    logic [DATAWIDTH_CSADDR-1:0]        w_nextAddr;
    logic                               w_exec;
    logic                               w_memWait;
    logic                               w_retire;

    assign w_aSel  = r_mir[34] ? {1'b0, bus.RegIR_RS1} : r_mir[40:35];
    assign w_bSel  = r_mir[27] ? {1'b0, bus.RegIR_RS2} : r_mir[33:28];
    assign w_cSel  = r_mir[20] ? {1'b0, bus.RegIR_RD}  : r_mir[26:21];
    assign w_rd    = r_mir[19];
    assign w_wr    = r_mir[18];
    assign w_alu   = r_mir[17:14];
    assign w_cond  = r_mir[13:11];
    assign w_jaddr = r_mir[10:0];

    assign w_exec    = (r_state == c_EXEC);
    assign w_memWait = (w_rd | w_wr) & ~bus.uControl_MemReady_InHigh;
    assign w_retire  = w_exec & ~w_memWait;

    // Natural overflow of the 11-bit add gives the 0x7FF -> 0x000 wrap.
    assign w_csarInc = r_csAddr + {{(DATAWIDTH_CSADDR-1){1'b0}}, 1'b1};

    // Format-3 instructions (OP[1]=1) dispatch on OP3, the others on OP2.
    assign w_decodeAddr = bus.RegIR_OP[1] ? {1'b1, bus.RegIR_OP, bus.RegIR_OP3, 2'b00}
                                          : {1'b1, bus.RegIR_OP, bus.RegIR_OP2, 3'b000, 2'b00};

    always_comb begin
        w_nextAddr = w_csarInc;
        case (w_cond)
            3'b001:  w_nextAddr = bus.PSR_Negative_InHigh ? w_jaddr : w_csarInc;
            3'b010:  w_nextAddr = bus.PSR_Zero_InHigh     ? w_jaddr : w_csarInc;
            3'b011:  w_nextAddr = bus.PSR_Overflow_InHigh ? w_jaddr : w_csarInc;
            3'b100:  w_nextAddr = bus.PSR_Carry_InHigh    ? w_jaddr : w_csarInc;
            3'b101:  w_nextAddr = bus.RegIR_BIT13         ? w_jaddr : w_csarInc;
            3'b110:  w_nextAddr = w_jaddr;
            3'b111:  w_nextAddr = w_decodeAddr;
            default: w_nextAddr = w_csarInc;
        endcase
    end

    always_ff @(posedge uControl_CLOCK_50) begin
        if (uControl_Reset_InHigh) begin
            r_state  <= c_LOAD;
            r_csAddr <= DATA_CSADDR_INIT;
            r_mir    <= '0;
        end else begin
            case (r_state)
                c_LOAD: begin
                    r_mir   <= bus.uControl_CSData_In;
                    r_state <= c_EXEC;
                end
                default: begin
                    if (!w_memWait) begin
                        r_csAddr <= w_nextAddr;
                        r_state  <= c_LOAD;
                    end
                end
            endcase
        end
    end

    assign bus.uControl_CSAddress_Out    = r_csAddr;
    assign bus.MUX_SelectionBUSA_Out     = w_aSel;
    assign bus.MUX_SelectionBUSB_Out     = w_bSel;
    assign bus.Decoder_SelectionC_Out    = w_cSel;
    assign bus.ALU_Selection_Out         = w_alu;
    assign bus.uControl_MemRD_OutHigh    = w_exec & w_rd;
    assign bus.uControl_MemWR_OutHigh    = w_exec & w_wr;
    // A reset arriving in the retiring cycle aborts the register write.
    assign bus.uControl_RegWrite_OutHigh = w_retire & (w_cSel != '0) & ~uControl_Reset_InHigh;
endmodule
`default_nettype wire

// File: tb/tb_ucontrol_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ucontrol_sequencer
// Brief    : Directed + randomized checks of ucontrol_sequencer against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucontrol_sequencer;
    logic clk;
    logic rst;
    int   nChecks;
    int   nPass;
    int   expAddr;
    logic [40:0] rom [0:2047];

    ucontrol_sequencer_if bus ();

    ucontrol_sequencer dut (
        .uControl_CLOCK_50     (clk),
        .uControl_Reset_InHigh (rst),
        .bus                   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous control store: address sampled mid-cycle, data held to the next rising edge.
    always @(negedge clk) bus.uControl_CSData_In <= rom[bus.uControl_CSAddress_Out];

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [40:0] mkWord(input int a, input int amux, input int b, input int bmux,
                                           input int c, input int cmux, input int rd, input int wr,
                                           input int alu, input int cond, input int jaddr);
        logic [40:0] w;
        w = {a[5:0], amux[0], b[5:0], bmux[0], c[5:0], cmux[0], rd[0], wr[0], alu[3:0], cond[2:0], jaddr[10:0]};
        return w;
    endfunction

    // Reference next-address rule in plain integer arithmetic.
    function automatic int modelNext(input int csar, input int cond, input int jaddr);
        int taken;
        int op;
        op = int'(bus.RegIR_OP);
        if (cond == 7)
            return (op >= 2) ? 1024 + op * 256 + int'(bus.RegIR_OP3) * 4
                             : 1024 + op * 256 + int'(bus.RegIR_OP2) * 32;
        case (cond)
            1: taken = int'(bus.PSR_Negative_InHigh);
            2: taken = int'(bus.PSR_Zero_InHigh);
            3: taken = int'(bus.PSR_Overflow_InHigh);
            4: taken = int'(bus.PSR_Carry_InHigh);
            5: taken = int'(bus.RegIR_BIT13);
            6: taken = 1;
            default: taken = 0;
        endcase
        return (taken != 0) ? jaddr : (csar + 1) % 2048;
    endfunction

    task automatic setFlags(input logic n, input logic z, input logic v, input logic c, input logic b13);
        bus.PSR_Negative_InHigh = n;
        bus.PSR_Zero_InHigh     = z;
        bus.PSR_Overflow_InHigh = v;
        bus.PSR_Carry_InHigh    = c;
        bus.RegIR_BIT13         = b13;
    endtask

    // Entered 1ns after the edge that puts the DUT in LOAD; leaves at the same point of the next LOAD.
    task automatic doInstr(input logic [40:0] w, input int waits);
        int   mem;
        int   nWait;
        int   aExp;
        int   bExp;
        int   cExp;
        logic sn;
        logic sz;
        logic sv;
        logic sc;
        rom[expAddr] = w;
        bus.uControl_MemReady_InHigh = 1'($urandom);
        #1;
        chk("load_csar", 16'(bus.uControl_CSAddress_Out), 16'(expAddr));
        chk("load_rd", 16'(bus.uControl_MemRD_OutHigh), 16'd0);
        chk("load_wr", 16'(bus.uControl_MemWR_OutHigh), 16'd0);
        chk("load_regw", 16'(bus.uControl_RegWrite_OutHigh), 16'd0);
        @(posedge clk); #1;
        mem   = int'(w[19] | w[18]);
        nWait = (mem != 0) ? waits : 0;
        {sn, sz, sv, sc} = {bus.PSR_Negative_InHigh, bus.PSR_Zero_InHigh,
                            bus.PSR_Overflow_InHigh, bus.PSR_Carry_InHigh};
        for (int k = 0; k <= nWait; k++) begin
            if (k == nWait) begin
                {bus.PSR_Negative_InHigh, bus.PSR_Zero_InHigh,
                 bus.PSR_Overflow_InHigh, bus.PSR_Carry_InHigh} = {sn, sz, sv, sc};
                bus.uControl_MemReady_InHigh = (mem != 0) ? 1'b1 : 1'($urandom);
            end else begin
                {bus.PSR_Negative_InHigh, bus.PSR_Zero_InHigh,
                 bus.PSR_Overflow_InHigh, bus.PSR_Carry_InHigh} = 4'($urandom);
                bus.uControl_MemReady_InHigh = 1'b0;
            end
            #1;
            aExp = w[34] ? int'(bus.RegIR_RS1) : int'(w[40:35]);
            bExp = w[27] ? int'(bus.RegIR_RS2) : int'(w[33:28]);
            cExp = w[20] ? int'(bus.RegIR_RD)  : int'(w[26:21]);
            chk("exec_csar", 16'(bus.uControl_CSAddress_Out), 16'(expAddr));
            chk("exec_rd", 16'(bus.uControl_MemRD_OutHigh), 16'(w[19]));
            chk("exec_wr", 16'(bus.uControl_MemWR_OutHigh), 16'(w[18]));
            chk("exec_busa", 16'(bus.MUX_SelectionBUSA_Out), 16'(aExp));
            chk("exec_busb", 16'(bus.MUX_SelectionBUSB_Out), 16'(bExp));
            chk("exec_busc", 16'(bus.Decoder_SelectionC_Out), 16'(cExp));
            chk("exec_alu", 16'(bus.ALU_Selection_Out), 16'(w[17:14]));
            chk("exec_regw", 16'(bus.uControl_RegWrite_OutHigh),
                16'((k == nWait) && (cExp != 0)));
            if (k == nWait) expAddr = modelNext(expAddr, int'(w[13:11]), int'(w[10:0]));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [63:0] rnd;
        logic [40:0] w;
        nChecks = 0;
        nPass   = 0;
        for (int i = 0; i < 2048; i++) rom[i] = '0;
        rst = 1'b1;
        bus.uControl_MemReady_InHigh = 1'b0;
        setFlags(0, 0, 0, 0, 0);
        bus.RegIR_OP = 2'd0; bus.RegIR_RD = 5'd0; bus.RegIR_OP2 = 3'd0;
        bus.RegIR_OP3 = 6'd0; bus.RegIR_RS1 = 5'd0; bus.RegIR_RS2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_csar", 16'(bus.uControl_CSAddress_Out), 16'h000);
        chk("rst_busa", 16'(bus.MUX_SelectionBUSA_Out), 16'd0);
        chk("rst_busb", 16'(bus.MUX_SelectionBUSB_Out), 16'd0);
        chk("rst_busc", 16'(bus.Decoder_SelectionC_Out), 16'd0);
        chk("rst_alu", 16'(bus.ALU_Selection_Out), 16'd0);
        chk("rst_regw", 16'(bus.uControl_RegWrite_OutHigh), 16'd0);
        chk("rst_rd", 16'(bus.uControl_MemRD_OutHigh), 16'd0);
        chk("rst_wr", 16'(bus.uControl_MemWR_OutHigh), 16'd0);
        expAddr = 0;

        // Sequential word with C=5.
        doInstr(mkWord(1, 0, 2, 0, 5, 0, 0, 0, 3, 0, 0), 0);

        // Each conditional jump, taken and not taken.
        for (int c = 1; c <= 5; c++) begin
            for (int v = 0; v < 2; v++) begin
                setFlags(c == 1 && v == 1, c == 2 && v == 1, c == 3 && v == 1,
                         c == 4 && v == 1, c == 5 && v == 1);
                doInstr(mkWord(0, 0, 0, 0, 0, 0, 0, 0, 0, c, 'h123), 0);
            end
        end
        setFlags(0, 0, 0, 0, 0);

        // Wrap from 0x7FF.
        doInstr(mkWord(0, 0, 0, 0, 1, 0, 0, 0, 0, 6, 'h7FF), 0);
        doInstr(mkWord(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0);
        chk("wrap_csar", 16'(bus.uControl_CSAddress_Out), 16'h000);

        // Instruction decode.
        bus.RegIR_OP = 2'b10; bus.RegIR_OP3 = 6'h00;
        doInstr(mkWord(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0), 0);
        chk("dec_op2", 16'(bus.uControl_CSAddress_Out), 16'h600);
        bus.RegIR_OP = 2'b00; bus.RegIR_OP2 = 3'b010;
        doInstr(mkWord(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0), 0);
        chk("dec_op0", 16'(bus.uControl_CSAddress_Out), 16'h440);
        bus.RegIR_OP = 2'b01; bus.RegIR_OP2 = 3'b000;
        doInstr(mkWord(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0), 0);
        chk("dec_op1", 16'(bus.uControl_CSAddress_Out), 16'h500);

        // IR-sourced register selects.
        bus.RegIR_RS1 = 5'd3; bus.RegIR_RS2 = 5'd7; bus.RegIR_RD = 5'd9;
        doInstr(mkWord(12, 1, 13, 1, 14, 1, 0, 0, 5, 0, 0), 0);

        // Memory read with three wait cycles, then a read+write pair.
        doInstr(mkWord(1, 0, 1, 0, 2, 0, 1, 0, 0, 0, 0), 3);
        doInstr(mkWord(1, 0, 1, 0, 2, 0, 1, 1, 0, 0, 0), 2);

        // Randomized microwords, flags, IR fields and wait lengths.
        for (int i = 0; i < 150; i++) begin
            rnd = {$urandom, $urandom};
            w   = rnd[40:0];
            setFlags(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            bus.RegIR_OP  = 2'($urandom); bus.RegIR_RD  = 5'($urandom);
            bus.RegIR_OP2 = 3'($urandom); bus.RegIR_OP3 = 6'($urandom);
            bus.RegIR_RS1 = 5'($urandom); bus.RegIR_RS2 = 5'($urandom);
            doInstr(w, int'($urandom_range(0, 3)));
        end

        // Reset during a memory wait aborts the microinstruction.
        w = mkWord(0, 0, 0, 0, 6, 0, 1, 0, 2, 6, 'h055);
        rom[expAddr] = w;
        @(posedge clk); #1;
        bus.uControl_MemReady_InHigh = 1'b0;
        #1;
        chk("wait_rd", 16'(bus.uControl_MemRD_OutHigh), 16'd1);
        rst = 1'b1;
        bus.uControl_MemReady_InHigh = 1'b1;
        #1;
        chk("abort_regw", 16'(bus.uControl_RegWrite_OutHigh), 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_csar", 16'(bus.uControl_CSAddress_Out), 16'h000);
        chk("abort_rd", 16'(bus.uControl_MemRD_OutHigh), 16'd0);
        chk("abort_busc", 16'(bus.Decoder_SelectionC_Out), 16'd0);
        expAddr = 0;
        setFlags(0, 0, 0, 0, 0);
        doInstr(mkWord(0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
`default_nettype wire
